present_core: RTL

Parametrised iterative PRESENT block cipher core, successor to the fixed PRESENT-80 encrypt-only core. It supports 80- or 128-bit keys (elaboration-time) and encryption or decryption (per-operation). It computes one round per clock, with an internal forward key walk that derives the last round key for decryption. It sits behind the same start/ready handshake as the earlier core and drops into the existing crypto datapath.

---
 rtl/present_core.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/present_core.sv
// present_core: iterative PRESENT block cipher, one round per clock.
// 80- or 128-bit key chosen at elaboration; encrypt or decrypt per operation.
// Decryption first walks the key schedule forward to K_32, then runs the
// rounds backwards while stepping the key register back one round at a time.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for sta; out/rdy hold the last result
// ENC   | rounds 1..31, then final whitening into out
// KWALK | key register steps forward to K_32; data untouched
// DEC   | inverse rounds 31..1; last one writes out
module present_core #(
    parameter int KEY_BITS = 80
) (
    input  logic                ck,
    input  logic                rst,
    input  logic                sta,
    input  logic                dec,
    input  logic [0:63]         inp,
    input  logic [0:KEY_BITS-1] key,
    output logic                bsy,
    output logic                rdy,
    output logic [0:63]         out
);

    generate
        if (KEY_BITS != 80 && KEY_BITS != 128) begin : g_bad_key_bits
            $error("present_core: KEY_BITS must be 80 or 128");
        end
    endgenerate

    // number of top key nibbles passed through the S-box, and LSB of the counter field
    localparam int NIB = (KEY_BITS == 128) ? 2 : 1;
    localparam int RCL = (KEY_BITS == 128) ? 62 : 15;

    typedef enum logic [1:0] {IDLE, ENC, KWALK, DEC} state_t;

    state_t              st, st_n;
    logic [63:0]         sr, sr_n;
    logic [KEY_BITS-1:0] kr, kr_n;
    logic [4:0]          rc, rc_n;
    logic                fin, fin_n;
    logic [63:0]         out_n;
    logic                rdy_n, bsy_n;

    logic [63:0]         rk;
    logic [63:0]         estep;
    logic [63:0]         dstep;

    function automatic logic [3:0] sb(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hC;  4'h1: y = 4'h5;  4'h2: y = 4'h6;  4'h3: y = 4'hB;
            4'h4: y = 4'h9;  4'h5: y = 4'h0;  4'h6: y = 4'hA;  4'h7: y = 4'hD;
            4'h8: y = 4'h3;  4'h9: y = 4'hE;  4'hA: y = 4'hF;  4'hB: y = 4'h8;
            4'hC: y = 4'h4;  4'hD: y = 4'h7;  4'hE: y = 4'h1;  default: y = 4'h2;
        endcase
        return y;
    endfunction

    function automatic logic [3:0] sbi(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'h5;  4'h1: y = 4'hE;  4'h2: y = 4'hF;  4'h3: y = 4'h8;
            4'h4: y = 4'hC;  4'h5: y = 4'h1;  4'h6: y = 4'h2;  4'h7: y = 4'hD;
            4'h8: y = 4'hB;  4'h9: y = 4'h4;  4'hA: y = 4'h6;  4'hB: y = 4'h3;
            4'hC: y = 4'h0;  4'hD: y = 4'h7;  4'hE: y = 4'h9;  default: y = 4'hA;
        endcase
        return y;
    endfunction

    function automatic logic [63:0] sl(input logic [63:0] s);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 16; i++) y[4*i +: 4] = sb(s[4*i +: 4]);
        return y;
    endfunction

    function automatic logic [63:0] sli(input logic [63:0] s);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 16; i++) y[4*i +: 4] = sbi(s[4*i +: 4]);
        return y;
    endfunction

    // bit i moves to 16*i mod 63; bit 63 stays put
    function automatic logic [63:0] pl(input logic [63:0] s);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 63; i++) y[(16 * i) % 63] = s[i];
        y[63] = s[63];
        return y;
    endfunction

    function automatic logic [63:0] pli(input logic [63:0] s);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 63; i++) y[i] = s[(16 * i) % 63];
        y[63] = s[63];
        return y;
    endfunction

    function automatic logic [KEY_BITS-1:0] kup(input logic [KEY_BITS-1:0] k, input logic [4:0] r);
        logic [KEY_BITS-1:0] t;
        t = {k[KEY_BITS-62:0], k[KEY_BITS-1:KEY_BITS-61]};
        t[KEY_BITS-1 -: 4] = sb(t[KEY_BITS-1 -: 4]);
        if (NIB == 2) t[KEY_BITS-5 -: 4] = sb(t[KEY_BITS-5 -: 4]);
        t[RCL +: 5] = t[RCL +: 5] ^ r;
        return t;
    endfunction

    function automatic logic [KEY_BITS-1:0] kinv(input logic [KEY_BITS-1:0] k, input logic [4:0] r);
        logic [KEY_BITS-1:0] t;
        t = k;
        t[RCL +: 5] = t[RCL +: 5] ^ r;
        t[KEY_BITS-1 -: 4] = sbi(t[KEY_BITS-1 -: 4]);
        if (NIB == 2) t[KEY_BITS-5 -: 4] = sbi(t[KEY_BITS-5 -: 4]);
        return {t[60:0], t[KEY_BITS-1:61]};
    endfunction

    assign rk    = kr[KEY_BITS-1 -: 64];
    assign estep = pl(sl(sr ^ rk));
    assign dstep = sli(pli(sr)) ^ rk;

    // state register
    always_ff @(posedge ck or posedge rst) begin
        if (rst) st <= IDLE;
        else     st <= st_n;
    end

    // next-state decode; fin marks the extra edge after round 31
    always_comb begin
        st_n = st;
        case (st)
            IDLE:    if (sta) st_n = dec ? KWALK : ENC;
            ENC:     if (fin) st_n = IDLE;
            KWALK:   if (fin) st_n = DEC;
            DEC:     if (rc == 5'd1) st_n = IDLE;
            default: st_n = IDLE;
        endcase
    end

    // datapath and output next values for the current state
    always_comb begin
        sr_n  = sr;
        kr_n  = kr;
        rc_n  = rc;
        fin_n = fin;
        out_n = out;
        rdy_n = rdy;
        bsy_n = bsy;
        case (st)
            IDLE: begin
                if (sta) begin
                    sr_n  = inp;
                    kr_n  = key;
                    rc_n  = 5'd1;
                    fin_n = 1'b0;
                    rdy_n = 1'b0;
                    bsy_n = 1'b1;
                end
            end
            ENC: begin
                if (!fin) begin
                    sr_n = estep;
                    kr_n = kup(kr, rc);
                    if (rc == 5'd31) fin_n = 1'b1;
                    else             rc_n  = rc + 5'd1;
                end else begin
                    out_n = sr ^ rk;
                    rdy_n = 1'b1;
                    bsy_n = 1'b0;
                    fin_n = 1'b0;
                end
            end
            KWALK: begin
                if (!fin) begin
                    kr_n = kup(kr, rc);
                    if (rc == 5'd31) fin_n = 1'b1;
                    else             rc_n  = rc + 5'd1;
                end else begin
                    sr_n  = sr ^ rk;
                    kr_n  = kinv(kr, 5'd31);
                    rc_n  = 5'd31;
                    fin_n = 1'b0;
                end
            end
            DEC: begin
                if (rc == 5'd1) begin
                    out_n = dstep;
                    rdy_n = 1'b1;
                    bsy_n = 1'b0;
                end else begin
                    sr_n = dstep;
                    kr_n = kinv(kr, rc - 5'd1);
                    rc_n = rc - 5'd1;
                end
            end
            default: ;
        endcase
    end

    // datapath and output registers
    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            sr  <= '0;
            kr  <= '0;
            rc  <= '0;
            fin <= 1'b0;
            out <= '0;
            rdy <= 1'b0;
            bsy <= 1'b0;
        end else begin
            sr  <= sr_n;
            kr  <= kr_n;
            rc  <= rc_n;
            fin <= fin_n;
            out <= out_n;
            rdy <= rdy_n;
            bsy <= bsy_n;
        end
    end

endmodule
